// File: rtl/adder_tree_operand_loader_pkg.sv
// Shared types and default sizes for the adder tree operand loader.
package adder_tree_pkg;

    localparam int ADDER_WIDTH  = 28;
    localparam int NUM_OPERANDS = 8;

    typedef logic [ADDER_WIDTH-1:0] operand_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_t;

endpackage

// File: rtl/adder_tree_operand_loader_slot_bank.sv
// Write-indexed operand register array with a per-slot valid mask.
// Slots whose mask bit is clear read as zero on the packed output, so a
// partially filled bank presents zeros to the unused tree leaves.
module operand_slot_bank #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   clr,
    output logic [DEPTH*WIDTH-1:0] ops
);

    logic [WIDTH-1:0] slot [DEPTH];
    logic [DEPTH-1:0] mask;

    // Store accepted operands and track which slots hold live data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot[k] <= '0;
            end
            mask <= '0;
        end else begin
            if (clr) begin
                mask <= '0;
            end
            if (wr_en) begin
                slot[wr_idx] <= wr_data;
                mask[wr_idx] <= 1'b1;
            end
        end
    end

    // Pack the bank, forcing unfilled slots to zero.
    always_comb begin
        ops = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ops[k*WIDTH +: WIDTH] = mask[k] ? slot[k] : '0;
        end
    end

endmodule

// File: rtl/adder_tree_operand_loader.sv
// Operand loader feeding the 8-input pipelined adder tree.
// Collects operands one per cycle, holds the completed bank stable until the
// tree takes it, and counts delivered banks.
// Optional macro LAST_FLUSH_EN adds in_last, which closes a short group early.
module adder_tree_operand_loader #(
    parameter  int ADDER_WIDTH  = adder_tree_pkg::ADDER_WIDTH,
    parameter  int NUM_OPERANDS = adder_tree_pkg::NUM_OPERANDS,
    localparam int IDX_W        = $clog2(NUM_OPERANDS),
    parameter  int CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDER_WIDTH-1:0]        in_data,
    input  logic                          in_valid,
`ifdef LAST_FLUSH_EN
    input  logic                          in_last,
`endif
    output logic                          in_ready,
    output logic [NUM_OPERANDS*ADDER_WIDTH-1:0] out_ops,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CNT_W-1:0]              group_count
);

    import adder_tree_pkg::*;

    loader_state_t    state;
    loader_state_t    state_nxt;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             handshake;
    logic             group_end;
    logic             last_op;

`ifdef LAST_FLUSH_EN
    assign last_op = in_last;
`else
    assign last_op = 1'b0;
`endif

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        handshake = 1'b0;
        group_end = 1'b0;
        case (state)
            FILL: begin
                in_ready  = ~rst;
                accept    = in_valid & ~rst;
                group_end = accept & ((idx == IDX_W'(NUM_OPERANDS - 1)) | last_op);
                if (group_end) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                out_valid = 1'b1;
                handshake = out_ready;
                if (handshake) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Write index: advance per accept, restart at slot 0 when a group closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (accept) begin
            idx <= group_end ? '0 : idx + 1'b1;
        end
    end

    // Delivered-bank counter; wraps naturally at its width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            group_count <= '0;
        end else if (handshake) begin
            group_count <= group_count + 1'b1;
        end
    end

    operand_slot_bank #(
        .WIDTH (ADDER_WIDTH),
        .DEPTH (NUM_OPERANDS),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_idx  (idx),
        .wr_data (in_data),
        .clr     (handshake),
        .ops     (out_ops)
    );

endmodule

// File: tb/tb_adder_tree_operand_loader.sv
// Self-checking bench for adder_tree_operand_loader. A second instance with a
// 4-bit counter exercises counter wrap in a short run.
module tb_adder_tree_operand_loader;

    localparam int W = 28;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic           out_ready = 1'b0;
    logic           in_ready, out_valid;
    logic [N*W-1:0] out_ops;
    logic [15:0]    group_count;
    logic           in_ready_s, out_valid_s;
    logic [N*W-1:0] out_ops_s;
    logic [3:0]     group_count_s;

    int checks = 0;
    int errors = 0;

    // Reference model: operands of the group being built / held, and delivered count
    logic [W-1:0] mq[$];
    bit           mfull;
    int           mgroups;

    always #5 clk = ~clk;

    adder_tree_operand_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
`ifdef LAST_FLUSH_EN
        .in_last(in_last),
`endif
        .in_ready(in_ready), .out_ops(out_ops), .out_valid(out_valid),
        .out_ready(out_ready), .group_count(group_count)
    );

    adder_tree_operand_loader #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
`ifdef LAST_FLUSH_EN
        .in_last(in_last),
`endif
        .in_ready(in_ready_s), .out_ops(out_ops_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .group_count(group_count_s)
    );

    function automatic logic [N*W-1:0] model_ops();
        logic [N*W-1:0] r = '0;
        for (int k = 0; k < mq.size(); k++) r[k*W +: W] = mq[k];
        return r;
    endfunction

    function automatic void model_reset();
        mq.delete();
        mfull = 0;
        mgroups = 0;
    endfunction

    // Apply one cycle of inputs, advance the model by the same edge.
    task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit l);
        bit lst;
        in_valid = v; in_data = d; out_ready = r; in_last = l;
`ifdef LAST_FLUSH_EN
        lst = l;
`else
        lst = 0;
`endif
        @(posedge clk);
        if (mfull) begin
            if (r) begin
                mfull = 0;
                mq.delete();
                mgroups++;
            end
        end else if (v) begin
            mq.push_back(d);
            if (mq.size() == N || lst) mfull = 1;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 0; out_ready = 0; in_last = 0;
        @(posedge clk); #1;
        model_reset();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        model_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        checks++; if (out_ops !== '0) begin errors++; $display("FAIL reset_out_ops got %h want 0", out_ops); end
        checks++; if (group_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", group_count); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_basic_group();
        for (int i = 1; i <= N; i++) begin
            drive(1, W'(i), 1, 0);
            if (i == N - 1) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b want 0", out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %0b want 1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready got %0b want 0", in_ready); end
        checks++; if (out_ops[0 +: W] !== W'(1)) begin errors++; $display("FAIL basic_slot0 got %0d want 1", out_ops[0 +: W]); end
        checks++; if (out_ops[7*W +: W] !== W'(8)) begin errors++; $display("FAIL basic_slot7 got %0d want 8", out_ops[7*W +: W]); end
        checks++; if (out_ops !== model_ops()) begin errors++; $display("FAIL basic_bank got %h want %h", out_ops, model_ops()); end
        drive(0, '0, 1, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_after_hs_valid got %0b want 0", out_valid); end
        checks++; if (group_count !== 16'd1) begin errors++; $display("FAIL basic_count got %0d want 1", group_count); end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] held;
        logic [W-1:0]   hold_d;
        for (int i = 0; i < N; i++) drive(1, W'($urandom), 0, 0);
        held = out_ops;
        checks++; if (held !== model_ops()) begin errors++; $display("FAIL bp_bank got %h want %h", held, model_ops()); end
        hold_d = W'($urandom) | W'(1);
        for (int c = 0; c < 5; c++) begin
            drive(1, hold_d, 0, 0);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %0b want 0", c, in_ready); end
            checks++; if (out_ops !== held) begin errors++; $display("FAIL bp_stable cyc %0d got %h want %h", c, out_ops, held); end
        end
        drive(1, hold_d, 1, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_hs_valid got %0b want 0", out_valid); end
        checks++; if (group_count !== 16'(mgroups)) begin errors++; $display("FAIL bp_count got %0d want %0d", group_count, mgroups); end
        drive(1, hold_d, 0, 0);
        for (int i = 1; i < N; i++) drive(1, W'($urandom), 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got %0b want 1", out_valid); end
        checks++; if (out_ops[0 +: W] !== hold_d) begin errors++; $display("FAIL bp_next_slot0 got %h want %h", out_ops[0 +: W], hold_d); end
        checks++; if (out_ops !== model_ops()) begin errors++; $display("FAIL bp_next_bank got %h want %h", out_ops, model_ops()); end
        drive(0, '0, 1, 0);
    endtask

    task automatic test_max_operands();
        logic [31:0] s = '0;
        for (int i = 0; i < N; i++) drive(1, 28'hFFFFFFF, 0, 0);
        for (int k = 0; k < N; k++) begin
            checks++; if (out_ops[k*W +: W] !== 28'hFFFFFFF) begin errors++; $display("FAIL max_slot%0d got %h want fffffff", k, out_ops[k*W +: W]); end
            s += 32'(out_ops[k*W +: W]);
        end
        checks++; if (s !== 32'h7FFFFFF8) begin errors++; $display("FAIL max_sum got %h want 7ffffff8", s); end
        drive(0, '0, 1, 0);
    endtask

    task automatic test_reset_mid_group();
        for (int i = 0; i < 3; i++) drive(1, W'($urandom) | W'(1), 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", out_valid); end
        checks++; if (out_ops !== '0) begin errors++; $display("FAIL rstmid_ops got %h want 0", out_ops); end
        checks++; if (group_count !== 16'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", group_count); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) drive(1, W'($urandom), 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_group_valid got %0b want 1", out_valid); end
        checks++; if (out_ops !== model_ops()) begin errors++; $display("FAIL rstmid_group_bank got %h want %h", out_ops, model_ops()); end
        drive(0, '0, 1, 0);
    endtask

`ifdef LAST_FLUSH_EN
    task automatic test_last_flush();
        logic [31:0] s = '0;
        drive(1, W'(5), 0, 0);
        drive(1, W'(6), 0, 0);
        drive(1, W'(7), 0, 1);
        in_last = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL last_valid got %0b want 1", out_valid); end
        checks++; if (out_ops !== model_ops()) begin errors++; $display("FAIL last_bank got %h want %h", out_ops, model_ops()); end
        for (int k = 0; k < N; k++) s += 32'(out_ops[k*W +: W]);
        checks++; if (s !== 32'd18) begin errors++; $display("FAIL last_sum got %0d want 18", s); end
        drive(1, W'(9), 0, 1'b0);
        drive(0, '0, 1, 0);
        drive(0, '0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL last_novalid_ignored got %0b want 0", out_valid); end
    endtask
`endif

    task automatic test_random();
        bit l;
        for (int c = 0; c < 600; c++) begin
            l = ($urandom_range(0, 5) == 0);
            drive($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 1) == 1, l);
            checks++; if (in_ready !== !mfull) begin errors++; $display("FAIL rand_in_ready cyc %0d got %0b want %0b", c, in_ready, !mfull); end
            checks++; if (out_valid !== mfull) begin errors++; $display("FAIL rand_out_valid cyc %0d got %0b want %0b", c, out_valid, mfull); end
            checks++; if (out_ops !== model_ops()) begin errors++; $display("FAIL rand_ops cyc %0d got %h want %h", c, out_ops, model_ops()); end
            checks++; if (group_count !== 16'(mgroups)) begin errors++; $display("FAIL rand_count cyc %0d got %0d want %0d", c, group_count, mgroups); end
        end
        in_last = 0;
    endtask

    task automatic test_count_wrap();
        apply_reset();
        for (int g = 0; g < 17; g++) begin
            for (int i = 0; i < N; i++) drive(1, W'($urandom), 1, 0);
            drive(0, '0, 1, 0);
        end
        checks++; if (group_count !== 16'(mgroups)) begin errors++; $display("FAIL wrap_count16 got %0d want %0d", group_count, mgroups); end
        checks++; if (group_count_s !== 4'(mgroups)) begin errors++; $display("FAIL wrap_count4 got %0d want %0d", group_count_s, 4'(mgroups)); end
        checks++; if (out_ops_s !== out_ops || in_ready_s !== in_ready || out_valid_s !== out_valid) begin
            errors++; $display("FAIL wrap_small_side got %h/%0b/%0b want %h/%0b/%0b", out_ops_s, in_ready_s, out_valid_s, out_ops, in_ready, out_valid);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_group();
        test_backpressure();
        test_max_operands();
        test_reset_mid_group();
`ifdef LAST_FLUSH_EN
        test_last_flush();
`endif
        test_random();
        test_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
